// File: rtl/pipelined_alu.sv
// Handshaked, registered Hack-style ALU with carry/overflow flags.
// Optional shift-add multiply is compiled in when PIPELINED_ALU_MUL_EN is defined.
module pipelined_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    input  logic             mul,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             cy,
    output logic             ov
);
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_t;

    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             zr_q, zr_d, ng_q, ng_d, cy_q, cy_d, ov_q, ov_d;

    logic [WIDTH-1:0] x1, x2, y1, y2, core_r, core_out;
    logic [WIDTH:0]   sum;
    logic             core_cy, core_ov, accept, mul_req;

    always_comb begin
        x1       = zx ? '0 : x;
        x2       = nx ? ~x1 : x1;
        y1       = zy ? '0 : y;
        y2       = ny ? ~y1 : y1;
        sum      = {1'b0, x2} + {1'b0, y2};
        core_r   = f ? sum[WIDTH-1:0] : (x2 & y2);
        core_cy  = f & sum[WIDTH];
        core_ov  = f & (x2[WIDTH-1] == y2[WIDTH-1]) & (sum[WIDTH-1] != x2[WIDTH-1]);
        core_out = no ? ~core_r : core_r;
    end

    assign in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign accept   = in_valid && in_ready;

`ifdef PIPELINED_ALU_MUL_EN
    localparam int CW = $clog2(WIDTH + 1);
    logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
    logic [WIDTH-1:0] acc_step, mul_out;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             no_q, no_d;

    assign mul_req  = mul;
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_out  = no_q ? ~acc_step : acc_step;
`else
    logic unused_mul;
    assign unused_mul = mul;
    assign mul_req    = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        zr_d        = zr_q;
        ng_d        = ng_q;
        cy_d        = cy_q;
        ov_d        = ov_q;
`ifdef PIPELINED_ALU_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        no_d     = no_q;
`endif
        case (state_q)
`ifdef PIPELINED_ALU_MUL_EN
            MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_d       = mul_out;
                    zr_d        = (mul_out == '0);
                    ng_d        = mul_out[WIDTH-1];
                    cy_d        = 1'b0;
                    ov_d        = 1'b0;
                end
            end
`endif
            default: begin
                // Draining DONE falls back to IDLE unless a new bundle replaces it.
                if (state_q == DONE && out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
                if (accept) begin
                    if (mul_req) begin
                        state_d     = MUL;
                        out_valid_d = 1'b0;
`ifdef PIPELINED_ALU_MUL_EN
                        mcand_d  = x2;
                        mplier_d = y2;
                        acc_d    = '0;
                        cnt_d    = CW'(WIDTH);
                        no_d     = no;
`endif
                    end else begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        out_d       = core_out;
                        zr_d        = (core_out == '0);
                        ng_d        = core_out[WIDTH-1];
                        cy_d        = core_cy;
                        ov_d        = core_ov;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            zr_q        <= 1'b1;
            ng_q        <= 1'b0;
            cy_q        <= 1'b0;
            ov_q        <= 1'b0;
`ifdef PIPELINED_ALU_MUL_EN
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            no_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            zr_q        <= zr_d;
            ng_q        <= ng_d;
            cy_q        <= cy_d;
            ov_q        <= ov_d;
`ifdef PIPELINED_ALU_MUL_EN
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            no_q     <= no_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign zr        = zr_q;
    assign ng        = ng_q;
    assign cy        = cy_q;
    assign ov        = ov_q;
endmodule

// File: tb/tb_pipelined_alu.sv
// Directed bench for pipelined_alu (WIDTH=16): vector table plus backpressure,
// async-reset and (when PIPELINED_ALU_MUL_EN is defined) multiply sequences.
module tb_pipelined_alu;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [15:0] x = '0, y = '0, out;
    logic        zx = 0, nx = 0, zy = 0, ny = 0, f = 0, no = 0, mul = 0;
    logic        out_valid, out_ready = 1'b0;
    logic        zr, ng, cy, ov;

    int n_cmp = 0;
    int n_err = 0;

    pipelined_alu #(.WIDTH(16)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no), .mul(mul),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .zr(zr), .ng(ng), .cy(cy), .ov(ov)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [5:0]  ctrl;
        logic [15:0] o;
        logic        zr, ng, cy, ov;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [15:0] xv, input logic [15:0] yv, input logic [5:0] c, input logic m);
        in_valid = 1'b1;
        x = xv;
        y = yv;
        {zx, nx, zy, ny, f, no} = c;
        mul = m;
    endtask

    task automatic chk_bundle(input string name, input logic [15:0] o, input logic [3:0] flags);
        chk({name, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({name, ".out"}, {16'd0, out}, {16'd0, o});
        chk({name, ".flags"}, {28'd0, zr, ng, cy, ov}, {28'd0, flags});
    endtask

    initial begin
        //                x        y        zx nx zy ny f no   out      zr ng cy ov
        vecs[0]  = '{16'd5,    16'd3,    6'b000010, 16'd8,    1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{16'd3,    16'd5,    6'b010011, 16'hFFFE, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{16'h7FFF, 16'd1,    6'b000010, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{16'hFFFF, 16'd1,    6'b000010, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{16'h0F0F, 16'h00FF, 6'b000000, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{16'h1234, 16'h5678, 6'b101010, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{16'h1234, 16'h5678, 6'b111010, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{16'h1234, 16'h5678, 6'b111111, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{16'h1234, 16'h5678, 6'b001101, 16'hEDCB, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{16'h0005, 16'h9999, 6'b001110, 16'h0004, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{16'hAAAA, 16'h0003, 6'b110011, 16'hFFFD, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{16'h8000, 16'h8000, 6'b000010, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{16'h00F0, 16'h0F00, 6'b010101, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state
        #12;
        chk("rst.valid", {31'd0, out_valid}, 32'd0);
        chk("rst.out", {16'd0, out}, 32'd0);
        chk("rst.flags", {28'd0, zr, ng, cy, ov}, 32'b1000);
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
        reset_n = 1'b1;
        step();

        // Table vectors issued back-to-back with out_ready high
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].x, vecs[i].y, vecs[i].ctrl, 1'b0);
            step();
            chk_bundle($sformatf("vec%0d", i), vecs[i].o,
                       {vecs[i].zr, vecs[i].ng, vecs[i].cy, vecs[i].ov});
            chk($sformatf("vec%0d.in_ready", i), {31'd0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("drain.valid", {31'd0, out_valid}, 32'd0);
        chk("drain.in_ready", {31'd0, in_ready}, 32'd1);

        // Backpressure: result held, other inputs ignored
        out_ready = 1'b0;
        drive(16'd5, 16'd3, 6'b000010, 1'b0);
        step();
        drive(16'h7FFF, 16'd1, 6'b000010, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk_bundle($sformatf("bp%0d", i), 16'd8, 4'b0000);
            chk($sformatf("bp%0d.in_ready", i), {31'd0, in_ready}, 32'd0);
            step();
        end
        out_ready = 1'b1;
        drive(16'h0010, 16'h0020, 6'b000010, 1'b0);
        step();
        chk_bundle("bp_release", 16'h0030, 4'b0000);
        in_valid = 1'b0;
        step();

        // Async reset drops a held result immediately
        out_ready = 1'b0;
        drive(16'hFFFF, 16'd1, 6'b000010, 1'b0);
        step();
        in_valid = 1'b0;
        chk_bundle("pre_arst", 16'h0000, 4'b1010);
        #2 reset_n = 1'b0;
        #1;
        chk("arst.valid", {31'd0, out_valid}, 32'd0);
        chk("arst.flags", {28'd0, zr, ng, cy, ov}, 32'b1000);
        #2 reset_n = 1'b1;
        step();
        chk("arst.in_ready", {31'd0, in_ready}, 32'd1);

`ifdef PIPELINED_ALU_MUL_EN
        // 7*6: WIDTH cycles busy, result on cycle WIDTH+1
        out_ready = 1'b1;
        drive(16'd7, 16'd6, 6'b000000, 1'b1);
        step();
        in_valid = 1'b0;
        mul = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("mul_busy%0d", i), {30'd0, in_ready, out_valid}, 32'd0);
            if (i < 15) step();
        end
        step();
        chk_bundle("mul42", 16'd42, 4'b0000);
        drive(16'hFFFF, 16'd3, 6'b000000, 1'b1);
        step();
        in_valid = 1'b0;
        mul = 1'b0;
        for (int i = 0; i < 16; i++) step();
        chk_bundle("mul_neg", 16'hFFFD, 4'b0100);
        step();

        // Reset in the 8th cycle of a multiply
        drive(16'd9, 16'd9, 6'b000000, 1'b1);
        step();
        in_valid = 1'b0;
        mul = 1'b0;
        for (int i = 0; i < 7; i++) step();
        #2 reset_n = 1'b0;
        #1;
        chk("mul_rst.valid", {31'd0, out_valid}, 32'd0);
        chk("mul_rst.out", {16'd0, out}, 32'd0);
        chk("mul_rst.zr", {31'd0, zr}, 32'd1);
        #2 reset_n = 1'b1;
        step();
        chk("mul_rst.in_ready", {31'd0, in_ready}, 32'd1);
        drive(16'd20, 16'd22, 6'b000010, 1'b0);
        step();
        in_valid = 1'b0;
        chk_bundle("mul_rst.add", 16'd42, 4'b0000);
`else
        // mul ignored when the multiplier is not built
        out_ready = 1'b1;
        drive(16'd7, 16'd6, 6'b000010, 1'b1);
        step();
        in_valid = 1'b0;
        mul = 1'b0;
        chk_bundle("mul_off", 16'd13, 4'b0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
